// File: rtl/xcvr_test_pkg.sv
// ============================================================================
// Package : xcvr_test_pkg
// Brief   : Shared CSR map, bit indices, mode encoding and FSM type.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package xcvr_test_pkg;

  localparam logic [2:0] c_addr_control   = 3'd0;
  localparam logic [2:0] c_addr_status    = 3'd1;
  localparam logic [2:0] c_addr_word_cnt  = 3'd2;
  localparam logic [2:0] c_addr_errbit    = 3'd3;
  localparam logic [2:0] c_addr_errword   = 3'd4;

  localparam int c_ctrl_enable_bit = 0;
  localparam int c_ctrl_mode_bit   = 1;
  localparam int c_ctrl_clear_bit  = 2;
  localparam int c_stat_locked_bit = 0;
  localparam int c_stat_lol_bit    = 1;

  typedef enum logic [0:0] {
    MODE_PRBS7  = 1'b0,
    MODE_PRBS31 = 1'b1
  } prbs_mode_e;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } fsm_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/xcvr_prbs_checker_if.sv
// ============================================================================
// Interface : xcvr_prbs_checker_if
// Brief     : CSR slave bus (fixed read latency of one cycle, no waitrequest).
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xcvr_prbs_checker_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

`default_nettype wire

// File: rtl/xcvr_prbs_compare.sv
// ============================================================================
// Module : xcvr_prbs_compare
// Brief  : Predicts each bit from received taps and counts mismatching bits.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xcvr_prbs_compare
  import xcvr_test_pkg::*;
(
  input  wire logic [63:0] cur,
  input  wire logic [63:0] prev,
  input  wire logic        mode,
  output logic      [6:0]  errbits
);

  // Only the newest 31 bits of the previous word can ever be a tap.
  logic [94:0] w_hist;
  logic [63:0] w_mismatch;
  logic        w_unused_prev_lsbs;

  assign w_unused_prev_lsbs = ^prev[32:0];

  always_comb begin
    w_hist     = {cur, prev[63:33]};
    w_mismatch = '0;
    errbits    = '0;
    for (int i = 0; i < 64; i++) begin
      if (mode == MODE_PRBS31) begin
        w_mismatch[i] = w_hist[31+i] ^ w_hist[i] ^ w_hist[i+3];
      end else begin
        w_mismatch[i] = w_hist[31+i] ^ w_hist[i+24] ^ w_hist[i+25];
      end
      errbits = errbits + 7'(w_mismatch[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/xcvr_prbs_checker.sv
// ============================================================================
// Module : xcvr_prbs_checker
// Brief  : PRBS7/PRBS31 checker with lock FSM, saturating counters and CSRs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xcvr_prbs_checker
  import xcvr_test_pkg::*;
#(
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [63:0] pattern_in,
  input  wire logic        pattern_in_valid,
  xcvr_prbs_checker_if.slave csr,
  output logic             locked,
  output logic             error_pulse
);

  logic        enable_q, enable_d;
  prbs_mode_e  mode_q, mode_d;
  logic [63:0] prev_q, prev_d;
  logic        prev_valid_q, prev_valid_d;
  logic        cmp_valid_q, cmp_valid_d;
  logic [6:0]  errbits_q, errbits_d;
  fsm_state_e  state_q, state_d;
  logic [31:0] run_q, run_d;
  logic [31:0] word_count_q, word_count_d;
  logic [31:0] err_bit_count_q, err_bit_count_d;
  logic [31:0] err_word_count_q, err_word_count_d;
  logic        lol_q, lol_d;
  logic        error_pulse_q, error_pulse_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic [6:0]  w_errbits;
  logic        w_ctrl_wr, w_stat_wr, w_reseed, w_clear, w_word_err;
  prbs_mode_e  w_new_mode;
  logic [31:0] w_run_inc;
  logic        w_unused_wdata;

  assign w_unused_wdata = ^csr.avs_writedata[31:3];

  xcvr_prbs_compare u_compare (
    .cur     (pattern_in),
    .prev    (prev_q),
    .mode    (mode_q),
    .errbits (w_errbits)
  );

  always_comb begin
    w_ctrl_wr  = csr.avs_write && (csr.avs_address == c_addr_control);
    w_stat_wr  = csr.avs_write && (csr.avs_address == c_addr_status);
    w_new_mode = prbs_mode_e'(csr.avs_writedata[c_ctrl_mode_bit]);
    w_reseed   = w_ctrl_wr && (w_new_mode != mode_q);
    w_clear    = w_ctrl_wr && csr.avs_writedata[c_ctrl_clear_bit];
    w_word_err = (errbits_q != 7'd0);
    w_run_inc  = run_q + 32'd1;

    enable_d = w_ctrl_wr ? csr.avs_writedata[c_ctrl_enable_bit] : enable_q;
    mode_d   = w_ctrl_wr ? w_new_mode : mode_q;

    // Stage 1: seed or compare against the previous received word.
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    cmp_valid_d  = 1'b0;
    errbits_d    = w_errbits;
    if (!enable_q || w_reseed) begin
      prev_d       = '0;
      prev_valid_d = 1'b0;
    end else if (pattern_in_valid) begin
      prev_d       = pattern_in;
      prev_valid_d = 1'b1;
      cmp_valid_d  = prev_valid_q;
    end

    // Stage 2: lock FSM and counters.
    state_d          = state_q;
    run_d            = run_q;
    word_count_d     = word_count_q;
    err_bit_count_d  = err_bit_count_q;
    err_word_count_d = err_word_count_q;
    error_pulse_d    = 1'b0;
    lol_d            = lol_q;
    if (w_stat_wr && csr.avs_writedata[c_stat_lol_bit]) begin
      lol_d = 1'b0;
    end
    if (!enable_q || w_reseed) begin
      state_d = ST_SEARCH;
      run_d   = '0;
    end else if (cmp_valid_q) begin
      if (state_q == ST_SEARCH) begin
        if (w_word_err) begin
          run_d = '0;
        end else if (w_run_inc == 32'(LOCK_COUNT)) begin
          state_d = ST_LOCKED;
          run_d   = '0;
        end else begin
          run_d = w_run_inc;
        end
      end else begin
        word_count_d     = sat_add32(word_count_q, 32'd1);
        err_bit_count_d  = sat_add32(err_bit_count_q, {25'd0, errbits_q});
        err_word_count_d = sat_add32(err_word_count_q, {31'd0, w_word_err});
        if (w_word_err) begin
          error_pulse_d = 1'b1;
          if (w_run_inc == 32'(UNLOCK_COUNT)) begin
            state_d = ST_SEARCH;
            run_d   = '0;
            lol_d   = 1'b1;
          end else begin
            run_d = w_run_inc;
          end
        end else begin
          run_d = '0;
        end
      end
    end
    if (w_clear) begin
      word_count_d     = '0;
      err_bit_count_d  = '0;
      err_word_count_d = '0;
    end

    rvalid_d = csr.avs_read;
    rdata_d  = '0;
    if (csr.avs_read) begin
      case (csr.avs_address)
        c_addr_control: begin
          rdata_d[c_ctrl_enable_bit] = enable_q;
          rdata_d[c_ctrl_mode_bit]   = mode_q;
        end
        c_addr_status: begin
          rdata_d[c_stat_locked_bit] = (state_q == ST_LOCKED);
          rdata_d[c_stat_lol_bit]    = lol_q;
        end
        c_addr_word_cnt: rdata_d = word_count_q;
        c_addr_errbit:   rdata_d = err_bit_count_q;
        c_addr_errword:  rdata_d = err_word_count_q;
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q         <= 1'b0;
      mode_q           <= MODE_PRBS7;
      prev_q           <= '0;
      prev_valid_q     <= 1'b0;
      cmp_valid_q      <= 1'b0;
      errbits_q        <= '0;
      state_q          <= ST_SEARCH;
      run_q            <= '0;
      word_count_q     <= '0;
      err_bit_count_q  <= '0;
      err_word_count_q <= '0;
      lol_q            <= 1'b0;
      error_pulse_q    <= 1'b0;
      rdata_q          <= '0;
      rvalid_q         <= 1'b0;
    end else begin
      enable_q         <= enable_d;
      mode_q           <= mode_d;
      prev_q           <= prev_d;
      prev_valid_q     <= prev_valid_d;
      cmp_valid_q      <= cmp_valid_d;
      errbits_q        <= errbits_d;
      state_q          <= state_d;
      run_q            <= run_d;
      word_count_q     <= word_count_d;
      err_bit_count_q  <= err_bit_count_d;
      err_word_count_q <= err_word_count_d;
      lol_q            <= lol_d;
      error_pulse_q    <= error_pulse_d;
      rdata_q          <= rdata_d;
      rvalid_q         <= rvalid_d;
    end
  end

  assign locked                = (state_q == ST_LOCKED);
  assign error_pulse           = error_pulse_q;
  assign csr.avs_readdata      = rdata_q;
  assign csr.avs_readdatavalid = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_xcvr_prbs_checker.sv
// ============================================================================
// Module : tb_xcvr_prbs_checker
// Brief  : Directed self-checking bench for xcvr_prbs_checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xcvr_prbs_checker;
  import xcvr_test_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pattern_in;
  logic        pattern_in_valid;
  logic        locked;
  logic        error_pulse;

  xcvr_prbs_checker_if csr ();

  xcvr_prbs_checker #(
    .LOCK_COUNT   (16),
    .UNLOCK_COUNT (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pattern_in       (pattern_in),
    .pattern_in_valid (pattern_in_valid),
    .csr              (csr),
    .locked           (locked),
    .error_pulse      (error_pulse)
  );

  always #5 clk = ~clk;

  int n_tests   = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  logic [30:0] g_hist;
  logic        g_prbs7;
  logic [63:0] w;
  logic [31:0] rd;

  always @(negedge clk) begin
    if (error_pulse === 1'b1) pulse_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference generator: bit 0 of each word is the earliest bit.
  task automatic gen_word(output logic [63:0] word);
    logic b;
    for (int i = 0; i < 64; i++) begin
      b       = g_prbs7 ? (g_hist[6] ^ g_hist[5]) : (g_hist[30] ^ g_hist[27]);
      word[i] = b;
      g_hist  = {g_hist[29:0], b};
    end
  endtask

  task automatic send(input logic [63:0] word);
    @(negedge clk);
    pattern_in       = word;
    pattern_in_valid = 1'b1;
  endtask

  task automatic send_gen(input int n);
    logic [63:0] word;
    for (int k = 0; k < n; k++) begin
      gen_word(word);
      send(word);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pattern_in_valid = 1'b0;
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    pattern_in_valid  = 1'b0;
    csr.avs_address   = a;
    csr.avs_writedata = d;
    csr.avs_write     = 1'b1;
    @(negedge clk);
    csr.avs_write     = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    pattern_in_valid = 1'b0;
    csr.avs_address  = a;
    csr.avs_read     = 1'b1;
    @(posedge clk);
    #1;
    csr.avs_read = 1'b0;
    check({tag, "_rvalid"}, {31'd0, csr.avs_readdatavalid}, 32'd1);
    check(tag, csr.avs_readdata, exp);
  endtask

  initial begin
    reset             = 1'b1;
    pattern_in        = '0;
    pattern_in_valid  = 1'b0;
    csr.avs_address   = '0;
    csr.avs_read      = 1'b0;
    csr.avs_write     = 1'b0;
    csr.avs_writedata = '0;
    g_prbs7           = 1'b0;
    g_hist            = 31'h2A5C_31E7;

    repeat (3) @(negedge clk);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err_pulse", {31'd0, error_pulse}, 32'd0);
    check("rst_rvalid", {31'd0, csr.avs_readdatavalid}, 32'd0);
    reset = 1'b0;
    check_reg("rst_control", c_addr_control, 32'd0);
    check_reg("rst_status", c_addr_status, 32'd0);
    check_reg("rst_addr5", 3'd5, 32'd0);

    // PRBS31 acquisition: 1 seed + 16 clean words.
    csr_write(c_addr_control, 32'd3);
    send_gen(16);
    idle(3);
    check("p31_prelock", {31'd0, locked}, 32'd0);
    check_reg("p31_word_pre", c_addr_word_cnt, 32'd0);
    check_reg("p31_ebit_pre", c_addr_errbit, 32'd0);
    check_reg("p31_eword_pre", c_addr_errword, 32'd0);
    send_gen(1);
    idle(1);
    check("p31_lock_lat1", {31'd0, locked}, 32'd0);
    idle(1);
    check("p31_lock_lat2", {31'd0, locked}, 32'd1);
    send_gen(3);
    idle(3);
    check_reg("p31_word3", c_addr_word_cnt, 32'd3);
    check_reg("p31_ebit0", c_addr_errbit, 32'd0);
    check_reg("p31_status", c_addr_status, 32'd1);

    // Single flipped bit 40: hits itself, then taps for bits 4 and 7 of the next word.
    gen_word(w);
    send(w ^ (64'd1 << 40));
    send_gen(3);
    idle(3);
    check("flip_locked", {31'd0, locked}, 32'd1);
    check_reg("flip_word", c_addr_word_cnt, 32'd7);
    check_reg("flip_ebit", c_addr_errbit, 32'd3);
    check_reg("flip_eword", c_addr_errword, 32'd2);
    check("flip_pulses", pulse_cnt, 32'd2);

    // Four all-ones words force loss of lock.
    repeat (4) send(64'hFFFF_FFFF_FFFF_FFFF);
    idle(3);
    check("unlock_locked", {31'd0, locked}, 32'd0);
    check_reg("unlock_status", c_addr_status, 32'd2);
    check_reg("unlock_word", c_addr_word_cnt, 32'd11);
    check_reg("unlock_eword", c_addr_errword, 32'd6);
    check("unlock_pulses", pulse_cnt, 32'd6);
    csr_write(c_addr_status, 32'd2);
    check_reg("w1c_status", c_addr_status, 32'd0);

    // Re-enable, relock, then clear coinciding with the last increment.
    csr_write(c_addr_control, 32'd0);
    csr_write(c_addr_control, 32'd3);
    send_gen(20);
    idle(3);
    check("relock", {31'd0, locked}, 32'd1);
    check_reg("relock_word", c_addr_word_cnt, 32'd14);
    send_gen(5);
    @(negedge clk);
    pattern_in_valid  = 1'b0;
    csr.avs_address   = c_addr_control;
    csr.avs_writedata = 32'd7;
    csr.avs_write     = 1'b1;
    @(negedge clk);
    csr.avs_write     = 1'b0;
    check_reg("clr_word", c_addr_word_cnt, 32'd0);
    check_reg("clr_ebit", c_addr_errbit, 32'd0);
    check_reg("clr_eword", c_addr_errword, 32'd0);
    check_reg("clr_control", c_addr_control, 32'd3);
    check("clr_locked", {31'd0, locked}, 32'd1);

    // Saturation: preload WORD_COUNT near the top, then add 10.
    @(negedge clk);
    force dut.word_count_q = 32'hFFFF_FFF8;
    @(negedge clk);
    release dut.word_count_q;
    send_gen(10);
    idle(3);
    check_reg("sat_word", c_addr_word_cnt, 32'hFFFF_FFFF);
    check_reg("sat_eword", c_addr_errword, 32'd0);

    // PRBS7 data checked as PRBS31 never locks.
    csr_write(c_addr_control, 32'd0);
    csr_write(c_addr_control, 32'd3);
    g_prbs7 = 1'b1;
    g_hist  = 31'h0000_005A;
    for (int k = 0; k < 30; k++) begin
      send_gen(1);
      check("p7_as_p31", {31'd0, locked}, 32'd0);
    end
    idle(3);
    check("p7_as_p31_end", {31'd0, locked}, 32'd0);
    check_reg("p7_as_p31_status", c_addr_status, 32'd0);

    // Switch to PRBS7: reseed, then 16 clean words with gaps, lock on word 17.
    csr_write(c_addr_control, 32'd1);
    for (int k = 0; k < 16; k++) begin
      send_gen(1);
      if (k % 3 == 2) idle(2);
    end
    idle(3);
    check("p7_prelock", {31'd0, locked}, 32'd0);
    send_gen(1);
    idle(1);
    check("p7_lock_lat1", {31'd0, locked}, 32'd0);
    idle(1);
    check("p7_lock_lat2", {31'd0, locked}, 32'd1);
    check_reg("p7_status", c_addr_status, 32'd1);

    // Reset during a read drops the response.
    @(negedge clk);
    csr.avs_address = c_addr_word_cnt;
    csr.avs_read    = 1'b1;
    reset           = 1'b1;
    @(posedge clk);
    #1;
    check("rst_read_rvalid", {31'd0, csr.avs_readdatavalid}, 32'd0);
    check("rst_read_locked", {31'd0, locked}, 32'd0);
    @(negedge clk);
    csr.avs_read = 1'b0;
    reset        = 1'b0;
    check_reg("rst2_control", c_addr_control, 32'd0);
    check_reg("rst2_word", c_addr_word_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
